// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared core constants: data width, register index width,
//               named register indices and the default stack-pointer reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;

    localparam logic [XLEN-1:0] SP_RESET_DEFAULT = 32'h0000_0000;

endpackage : core_pkg

`default_nettype wire

// File: rtl/reg_file_if.sv
// ============================================================================
// Module      : reg_file_if
// Description : Register-file access bundle: two read ports and one write port.
//               The core side is the master; the register file is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_if
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
);

    logic [ADDR_WIDTH-1:0] A1;
    logic [ADDR_WIDTH-1:0] A2;
    logic [ADDR_WIDTH-1:0] A3;
    logic                  WE3;
    logic [DATA_WIDTH-1:0] WD3;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;

    modport master (
        output A1, A2, A3, WE3, WD3,
        input  RD1, RD2
    );

    modport slave (
        input  A1, A2, A3, WE3, WD3,
        output RD1, RD2
    );

endinterface : reg_file_if

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : 32-entry integer register file, two async read ports, one sync
//               write port, x0 hardwired to zero. Optional write-first
//               forwarding enabled by macro REG_FILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
    import core_pkg::*;
#(
    parameter int                    DATA_WIDTH = XLEN,
    parameter int                    ADDR_WIDTH = REG_ADDR_W,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = SP_RESET_DEFAULT
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    reg_file_if.slave   bus
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    assign w_regs[REG_ZERO] = '0;

    // One flop bank per architectural register; x0 has no storage.
    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
            localparam logic [DATA_WIDTH-1:0] c_rst_val = (i == REG_SP) ? SP_RESET : '0;

            logic [DATA_WIDTH-1:0] r_reg;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_reg <= c_rst_val;
                end else if (bus.WE3 && (bus.A3 == ADDR_WIDTH'(i))) begin
                    r_reg <= bus.WD3;
                end
            end

            assign w_regs[i] = r_reg;
        end
    endgenerate

    always_comb begin
        w_rd1 = w_regs[bus.A1];
        w_rd2 = w_regs[bus.A2];
`ifdef REG_FILE_BYPASS_EN
        // Forward write data to a matching read port; reset suppresses the write, so no forward.
        if (!RST && bus.WE3 && (bus.A3 != '0)) begin
            if (bus.A1 == bus.A3) begin
                w_rd1 = bus.WD3;
            end
            if (bus.A2 == bus.A3) begin
                w_rd2 = bus.WD3;
            end
        end
`endif
    end

    assign bus.RD1 = w_rd1;
    assign bus.RD2 = w_rd2;

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module      : tb_reg_file
// Description : Directed self-checking bench for reg_file; expected read data
//               is queued when stimulus is applied and popped at sampling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

    localparam logic [31:0] SP_DEF = 32'h0000_0000;
    localparam logic [31:0] SP_ALT = 32'h0000_1000;

    logic CLK;
    logic RST;
    logic clk_en;

    int n_cmp;
    int n_fail;

    logic [31:0] q_exp [$];
    string       q_tag [$];

    reg_file_if bus ();
    reg_file_if bus_sp ();

    reg_file dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    reg_file #(
        .SP_RESET (SP_ALT)
    ) dut_sp (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_sp.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = clk_en ? ~CLK : 1'b0;

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        e = q_exp.pop_front();
        t = q_tag.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %h expected %h", tag, t, obs, e);
        end
    endtask

    // Drive both read indices, queue the expectations, then sample.
    task automatic sample(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] e1, input logic [31:0] e2);
        bus.A1 = a1;
        bus.A2 = a2;
        q_tag.push_back("RD1"); q_exp.push_back(e1);
        q_tag.push_back("RD2"); q_exp.push_back(e2);
        #1;
        check(tag, bus.RD1);
        check(tag, bus.RD2);
    endtask

    task automatic wr(input logic we, input logic [4:0] a3, input logic [31:0] d);
        @(negedge CLK);
        bus.WE3 = we;
        bus.A3  = a3;
        bus.WD3 = d;
        @(posedge CLK);
        #1;
        bus.WE3 = 1'b0;
    endtask

    task automatic sample_sp(input string tag);
        q_tag.push_back("sp RD1"); q_exp.push_back(SP_ALT);
        #1;
        check(tag, bus_sp.RD1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clk_en = 1'b0;
        RST    = 1'b0;
        bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.WE3 = 1'b0; bus.WD3 = '0;
        bus_sp.A1 = 5'd2; bus_sp.A2 = 5'd0; bus_sp.A3 = '0; bus_sp.WE3 = 1'b0; bus_sp.WD3 = '0;

        // Reset with the clock parked low: contents must appear with no edge.
        #3 RST = 1'b1;
        #2 RST = 1'b0;
        #1;
        sample("rst_x0", 5'd0, 5'd0, 32'h0, 32'h0);
        for (int i = 1; i < 32; i++) begin
            sample("rst_val", 5'(i), 5'(32 - i),
                   (i == 2) ? SP_DEF : 32'h0, ((32 - i) == 2) ? SP_DEF : 32'h0);
        end
        sample_sp("rst_sp_override");

        clk_en = 1'b1;

        wr(1'b1, 5'd5, 32'hDEAD_BEEF);
        sample("basic_wr", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        sample("basic_neighbours", 5'd4, 5'd6, 32'h0, 32'h0);

        wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        sample("x0_protect", 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF);

        wr(1'b0, 5'd7, 32'h1234_5678);
        sample("we_gate", 5'd7, 5'd0, 32'h0, 32'h0);

        wr(1'b1, 5'd31, 32'h8000_0001);
        sample("top_entry", 5'd31, 5'd30, 32'h8000_0001, 32'h0);

        // Same-cycle read and write of x9.
        wr(1'b1, 5'd9, 32'h11);
        @(negedge CLK);
        bus.WE3 = 1'b1; bus.A3 = 5'd9; bus.WD3 = 32'h22;
`ifdef REG_FILE_BYPASS_EN
        sample("rw_pre", 5'd9, 5'd0, 32'h22, 32'h0);
`else
        sample("rw_pre", 5'd9, 5'd0, 32'h11, 32'h0);
`endif
        @(posedge CLK);
        #1;
        bus.WE3 = 1'b0;
        sample("rw_post", 5'd9, 5'd9, 32'h22, 32'h22);

        // A write aimed at x0 must never forward.
        @(negedge CLK);
        bus.WE3 = 1'b1; bus.A3 = 5'd0; bus.WD3 = 32'hCAFE_F00D;
        sample("x0_no_bypass", 5'd0, 5'd0, 32'h0, 32'h0);
        @(posedge CLK);
        #1;
        bus.WE3 = 1'b0;

        // Asynchronous reset in the middle of a pending write.
        wr(1'b1, 5'd3, 32'h0000_ABCD);
        sample("pre_rst_x3", 5'd3, 5'd5, 32'h0000_ABCD, 32'hDEAD_BEEF);
        @(negedge CLK);
        bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'h5555;
        #1 RST = 1'b1;
        sample("rst_async", 5'd3, 5'd5, 32'h0, 32'h0);
        @(posedge CLK);
        #1;
        sample("rst_edge", 5'd3, 5'd2, 32'h0, SP_DEF);
        sample_sp("rst_sp_again");
        @(negedge CLK);
        RST = 1'b0;
`ifdef REG_FILE_BYPASS_EN
        sample("rst_rel_pre", 5'd3, 5'd9, 32'h5555, 32'h0);
`else
        sample("rst_rel_pre", 5'd3, 5'd9, 32'h0, 32'h0);
`endif
        @(posedge CLK);
        #1;
        bus.WE3 = 1'b0;
        sample("rst_rel_post", 5'd3, 5'd3, 32'h5555, 32'h5555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_reg_file

`default_nettype wire
